pktunit_chan_arbiter: RTL and testbench
=======================================

Name: pktunit_chan_arbiter

Overview:
- Merges NUM_CH packet-unit input streams onto one packet-unit output stream, with packet-granular arbitration. Each stream has data, flags and eop sub-channels, each with its own valid/ready.
- Sits between the per-port feeders and a single-input DUT. Generalises the fixed per-socket wiring to a configurable channel count, data width, arbitration mode and per-channel enable.
- Tags every output beat with its source channel and keeps per-channel packet and beat counters.

Parameters:
- DATA_BYTES, 8, bytes per beat; data width is DATA_BYTES*8 and eop width is DATA_BYTES.
- NUM_CH, 3, number of input channels, 1..32.
- CH_W, $clog2(NUM_CH) with a minimum of 1, width of the channel tag.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- CNT_W, 32, counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_en  in  NUM_CH  per-channel arbitration enable
- clr_cnt  in  1  synchronous clear of all counters
- in_data_d[NUM_CH]  in  DATA_BYTES*8  input data per channel
- in_data_v[NUM_CH]  in  1  input data valid
- in_data_r[NUM_CH]  out  1  input data ready
- in_flags_d[NUM_CH]  in  8  input per-beat flags
- in_flags_v[NUM_CH]  in  1  input flags valid
- in_flags_r[NUM_CH]  out  1  input flags ready
- in_eop_d[NUM_CH]  in  DATA_BYTES  byte-valid mask; nonzero marks the last beat of a packet
- in_eop_v[NUM_CH]  in  1  input eop valid
- in_eop_r[NUM_CH]  out  1  input eop ready
- out_data_d  out  DATA_BYTES*8  output data
- out_data_v  out  1  output data valid
- out_data_r  in  1  output data ready
- out_flags_d  out  8  output flags
- out_flags_v  out  1  output flags valid
- out_flags_r  in  1  output flags ready
- out_eop_d  out  DATA_BYTES  output eop mask
- out_eop_v  out  1  output eop valid
- out_eop_r  in  1  output eop ready
- out_chan  out  CH_W  source channel of the current output beat
- pkt_cnt[NUM_CH]  out  CNT_W  packets forwarded per channel
- beat_cnt[NUM_CH]  out  CNT_W  beats forwarded per channel

Behaviour:
- Beat definition:
  - Channel i presents a beat when in_data_v, in_flags_v and in_eop_v are all 1.
  - All three ready outputs of a channel are always driven identically.
  - A beat is accepted on a cycle where ready and all three valids are 1.
- Output stage:
  - One register stage holds data, flags, eop and chan; the three out_*_v are driven identically from it.
  - The slot drains when out_data_r, out_flags_r and out_eop_r are all 1.
  - space = !slot_full || drain.
  - Input-to-output latency is 1 cycle; full throughput is 1 beat per cycle.
- Ready: in_*_r[i] = space && grant_valid && (grant == i). Readies of all other channels are 0.
- Arbiter state machine:
  - IDLE: candidates are channels with ch_en[i] = 1 and a full beat presented.
    - ARB_MODE 0 picks the first candidate at or after rr_ptr, wrapping modulo NUM_CH.
    - ARB_MODE 1 picks the lowest-index candidate.
    - The grant is combinational in the same cycle.
    - On acceptance with eop = 0: go to LOCKED and store lock_ch.
    - On acceptance with eop != 0 (single-beat packet): stay in IDLE.
  - LOCKED: grant = lock_ch only. ch_en is ignored, so a packet is never truncated.
    - On acceptance with eop != 0: go to IDLE.
  - rr_ptr update (mode 0 only): on every accepted eop beat, rr_ptr = (granted + 1) modulo NUM_CH.
- Counters:
  - beat_cnt[i] increments on every accepted beat from channel i.
  - pkt_cnt[i] increments on every accepted eop beat from channel i.
  - Both wrap at 2^CNT_W.
  - clr_cnt zeroes all counters and wins over a simultaneous increment.
- Reset (asynchronous, rst_n = 0):
  - State = IDLE, rr_ptr = 0, lock_ch = 0, slot empty.
  - All out_*_v = 0; out_data_d, out_flags_d, out_eop_d and out_chan = 0.
  - All counters = 0; all in_*_r = 0.
  - Reset mid-packet abandons the packet; the next beat after reset is arbitrated from IDLE.
- Boundaries:
  - No candidates: nothing is accepted, the slot drains normally, and out_*_v falls after the drain.
  - Output stalled with the slot full and no drain: all readies are 0 and state holds.
  - Partial valids on a channel (for example data_v without eop_v): that channel is not a candidate and is not accepted.
  - NUM_CH = 1: the arbiter degenerates to a pass-through, still with the register stage.

Test Plan:
- Single channel, 3-beat packet (eop 00,00,0F) on ch0, output always ready -> output beats appear at cycles +1,+2,+3, out_chan = 0, pkt_cnt[0] = 1, beat_cnt[0] = 3.
- Mode 0, ch0..ch2 each continuously offering 2-beat packets -> output packet order 0,1,2,0,...; no interleaving of beats within a packet.
- Mode 1, same stimulus as the previous case -> only ch0 is served while it stays valid; ch1 is served only after ch0 valid drops at a packet boundary.
- ch_en[1] dropped after the first beat of a ch1 packet -> that packet completes in full, after which ch1 gets no further grants.
- out_*_r held low for 5 cycles mid-packet -> out_*_v stays 1 with stable data, all in_*_r stay 0, and no beat is lost or duplicated after release.
- clr_cnt pulsed in the same cycle as an accepted eop beat -> pkt_cnt = 0 on the next cycle; rst_n asserted mid-packet -> all outputs go to 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/pktunit_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pktunit_chan_arbiter
// Description : Merges NUM_CH packet-unit input streams (data / flags / eop
//               sub-channels, each with valid/ready) onto one output stream.
//               Arbitration is packet-granular: once the first beat of a
//               packet is accepted from a channel, that channel owns the
//               output until its eop beat is accepted. Output goes through a
//               single register slot (1-cycle latency, 1 beat/cycle).
//               Every output beat is tagged with its source channel, and
//               per-channel packet and beat counters are kept.
// Ports       :
//   clk, rst_n                 clock, asynchronous active-low reset
//   ch_en[NUM_CH]              per-channel arbitration enable (ignored once
//                              a packet is in progress)
//   clr_cnt                    synchronous clear of all counters
//   in_{data,flags,eop}_{d,v,r}[NUM_CH]  input streams
//   out_{data,flags,eop}_{d,v,r}         output stream
//   out_chan                   source channel of the current output beat
//   pkt_cnt[NUM_CH]            packets forwarded per channel
//   beat_cnt[NUM_CH]           beats forwarded per channel
// Revision    : 1.0 - initial release
// ============================================================================
module pktunit_chan_arbiter #(
  parameter int DATA_BYTES = 8,
  parameter int NUM_CH     = 3,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ARB_MODE   = 0,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    clr_cnt,
  input  logic [DATA_BYTES*8-1:0] in_data_d  [NUM_CH],
  input  logic                    in_data_v  [NUM_CH],
  output logic                    in_data_r  [NUM_CH],
  input  logic [7:0]              in_flags_d [NUM_CH],
  input  logic                    in_flags_v [NUM_CH],
  output logic                    in_flags_r [NUM_CH],
  input  logic [DATA_BYTES-1:0]   in_eop_d   [NUM_CH],
  input  logic                    in_eop_v   [NUM_CH],
  output logic                    in_eop_r   [NUM_CH],
  output logic [DATA_BYTES*8-1:0] out_data_d,
  output logic                    out_data_v,
  input  logic                    out_data_r,
  output logic [7:0]              out_flags_d,
  output logic                    out_flags_v,
  input  logic                    out_flags_r,
  output logic [DATA_BYTES-1:0]   out_eop_d,
  output logic                    out_eop_v,
  input  logic                    out_eop_r,
  output logic [CH_W-1:0]         out_chan,
  output logic [CNT_W-1:0]        pkt_cnt    [NUM_CH],
  output logic [CNT_W-1:0]        beat_cnt   [NUM_CH]
);

  localparam int DW = DATA_BYTES * 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_lock_ch;

  logic              r_full;
  logic [DW-1:0]     r_data;
  logic [7:0]        r_flags;
  logic [DATA_BYTES-1:0] r_eop;
  logic [CH_W-1:0]   r_chan;

  logic [CNT_W-1:0]  r_pkt_cnt  [NUM_CH];
  logic [CNT_W-1:0]  r_beat_cnt [NUM_CH];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0]     w_beat;       // all three valids present
  logic [NUM_CH-1:0]     w_cand;       // enabled and presenting a beat
  logic                  w_lock_beat;  // locked channel presents a beat
  logic [CH_W-1:0]       w_grant;
  logic                  w_grant_v;
  int                    w_best_dist;
  int                    w_dist;
  logic                  w_drain;
  logic                  w_space;
  logic                  w_accept;
  logic [DW-1:0]         w_sel_data;
  logic [7:0]            w_sel_flags;
  logic [DATA_BYTES-1:0] w_sel_eop;
  logic                  w_sel_eop_nz;
  logic [CH_W-1:0]       w_rr_nxt;

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_beat[i] = in_data_v[i] & in_flags_v[i] & in_eop_v[i];
    end
  end

  assign w_cand = w_beat & ch_en;

  always_comb begin
    w_lock_beat = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_lock_ch == CH_W'(i)) begin
        w_lock_beat = w_beat[i];
      end
    end
  end

  assign w_drain  = r_full & out_data_r & out_flags_r & out_eop_r;
  assign w_space  = ~r_full | w_drain;
  assign w_accept = w_space & w_grant_v;

  // --------------------------------------------------------------------------
  // Arbiter: grant selection and next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = '0;
    w_grant_v   = 1'b0;
    w_best_dist = NUM_CH;
    w_dist      = 0;

    if (r_state == ST_LOCKED) begin
      // Enable is ignored here so a packet in flight is never truncated.
      w_grant   = r_lock_ch;
      w_grant_v = w_lock_beat;
    end else if (ARB_MODE == 0) begin
      // Round-robin: choose the candidate with the smallest forward
      // distance from rr_ptr (wrapping modulo NUM_CH).
      for (int i = 0; i < NUM_CH; i++) begin
        w_dist = i - int'(r_rr_ptr);
        if (w_dist < 0) begin
          w_dist = w_dist + NUM_CH;
        end
        if (w_cand[i] && (w_dist < w_best_dist)) begin
          w_best_dist = w_dist;
          w_grant     = CH_W'(i);
          w_grant_v   = 1'b1;
        end
      end
    end else begin
      // Fixed priority: lowest index wins.
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cand[i] && !w_grant_v) begin
          w_grant   = CH_W'(i);
          w_grant_v = 1'b1;
        end
      end
    end

    if (w_accept) begin
      w_state_nxt = w_sel_eop_nz ? ST_IDLE : ST_LOCKED;
    end
  end

  // Beat fields of the granted channel.
  always_comb begin
    w_sel_data  = '0;
    w_sel_flags = '0;
    w_sel_eop   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant == CH_W'(i)) begin
        w_sel_data  = in_data_d[i];
        w_sel_flags = in_flags_d[i];
        w_sel_eop   = in_eop_d[i];
      end
    end
  end

  assign w_sel_eop_nz = |w_sel_eop;
  assign w_rr_nxt     = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : (w_grant + CH_W'(1));

  // Readies are forced low while reset is asserted so no upstream beat is
  // considered consumed during reset.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_data_r[i]  = rst_n & w_space & w_grant_v & (w_grant == CH_W'(i));
      in_flags_r[i] = rst_n & w_space & w_grant_v & (w_grant == CH_W'(i));
      in_eop_r[i]   = rst_n & w_space & w_grant_v & (w_grant == CH_W'(i));
    end
  end

  // --------------------------------------------------------------------------
  // Arbiter state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_ch <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_sel_eop_nz) begin
          if (ARB_MODE == 0) begin
            r_rr_ptr <= w_rr_nxt;
          end
        end else begin
          r_lock_ch <= w_grant;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register slot
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
      r_eop   <= '0;
      r_chan  <= '0;
    end else if (w_accept) begin
      r_full  <= 1'b1;
      r_data  <= w_sel_data;
      r_flags <= w_sel_flags;
      r_eop   <= w_sel_eop;
      r_chan  <= w_grant;
    end else if (w_drain) begin
      r_full  <= 1'b0;
    end
  end

  assign out_data_d  = r_data;
  assign out_flags_d = r_flags;
  assign out_eop_d   = r_eop;
  assign out_chan    = r_chan;
  assign out_data_v  = r_full;
  assign out_flags_v = r_full;
  assign out_eop_v   = r_full;

  // --------------------------------------------------------------------------
  // Per-channel counters (clear has priority over increment)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pkt_cnt[i]  <= '0;
        r_beat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_cnt) begin
          r_pkt_cnt[i]  <= '0;
          r_beat_cnt[i] <= '0;
        end else if (w_accept && (w_grant == CH_W'(i))) begin
          r_beat_cnt[i] <= r_beat_cnt[i] + CNT_W'(1);
          if (w_sel_eop_nz) begin
            r_pkt_cnt[i] <= r_pkt_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pktunit_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pktunit_chan_arbiter
// Description : Randomized self-checking bench. Two arbiter instances (round
//               robin and fixed priority) see identical input streams; a
//               behavioural model per instance predicts readies, the output
//               slot contents and the per-channel counters every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pktunit_chan_arbiter;

  localparam int DB   = 8;
  localparam int DW   = DB * 8;
  localparam int NCH  = 3;
  localparam int CW   = 2;
  localparam int CNTW = 32;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0] ch_en;
  logic           clr_cnt;
  logic [DW-1:0]  in_data_d  [NCH];
  logic           in_data_v  [NCH];
  logic [7:0]     in_flags_d [NCH];
  logic           in_flags_v [NCH];
  logic [DB-1:0]  in_eop_d   [NCH];
  logic           in_eop_v   [NCH];
  logic           out_data_r, out_flags_r, out_eop_r;

  // Instance A: round robin
  logic            a_data_r [NCH], a_flags_r [NCH], a_eop_r [NCH];
  logic [DW-1:0]   a_out_d;
  logic [7:0]      a_out_f;
  logic [DB-1:0]   a_out_e;
  logic            a_out_dv, a_out_fv, a_out_ev;
  logic [CW-1:0]   a_chan;
  logic [CNTW-1:0] a_pkt [NCH], a_beat [NCH];

  // Instance B: fixed priority
  logic            b_data_r [NCH], b_flags_r [NCH], b_eop_r [NCH];
  logic [DW-1:0]   b_out_d;
  logic [7:0]      b_out_f;
  logic [DB-1:0]   b_out_e;
  logic            b_out_dv, b_out_fv, b_out_ev;
  logic [CW-1:0]   b_chan;
  logic [CNTW-1:0] b_pkt [NCH], b_beat [NCH];

  pktunit_chan_arbiter #(.DATA_BYTES(DB), .NUM_CH(NCH), .ARB_MODE(0), .CNT_W(CNTW)) u_dut_rr (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .clr_cnt(clr_cnt),
    .in_data_d(in_data_d), .in_data_v(in_data_v), .in_data_r(a_data_r),
    .in_flags_d(in_flags_d), .in_flags_v(in_flags_v), .in_flags_r(a_flags_r),
    .in_eop_d(in_eop_d), .in_eop_v(in_eop_v), .in_eop_r(a_eop_r),
    .out_data_d(a_out_d), .out_data_v(a_out_dv), .out_data_r(out_data_r),
    .out_flags_d(a_out_f), .out_flags_v(a_out_fv), .out_flags_r(out_flags_r),
    .out_eop_d(a_out_e), .out_eop_v(a_out_ev), .out_eop_r(out_eop_r),
    .out_chan(a_chan), .pkt_cnt(a_pkt), .beat_cnt(a_beat)
  );

  pktunit_chan_arbiter #(.DATA_BYTES(DB), .NUM_CH(NCH), .ARB_MODE(1), .CNT_W(CNTW)) u_dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .clr_cnt(clr_cnt),
    .in_data_d(in_data_d), .in_data_v(in_data_v), .in_data_r(b_data_r),
    .in_flags_d(in_flags_d), .in_flags_v(in_flags_v), .in_flags_r(b_flags_r),
    .in_eop_d(in_eop_d), .in_eop_v(in_eop_v), .in_eop_r(b_eop_r),
    .out_data_d(b_out_d), .out_data_v(b_out_dv), .out_data_r(out_data_r),
    .out_flags_d(b_out_f), .out_flags_v(b_out_fv), .out_flags_r(out_flags_r),
    .out_eop_d(b_out_e), .out_eop_v(b_out_ev), .out_eop_r(out_eop_r),
    .out_chan(b_chan), .pkt_cnt(b_pkt), .beat_cnt(b_beat)
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural reference model (index 0 = round robin, 1 = fixed priority)
  // --------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] d;
    logic [7:0]    f;
    logic [DB-1:0] e;
    int            ch;
  } beat_t;

  bit          m_full [2];
  beat_t       m_slot [2];
  int          m_lock [2];        // channel owning the output, -1 when none
  int          m_rr   [2];
  int unsigned m_pkt  [2][NCH];
  int unsigned m_beat [2][NCH];

  task automatic model_reset(input int m);
    m_full[m] = 1'b0;
    m_lock[m] = -1;
    m_rr[m]   = 0;
    for (int i = 0; i < NCH; i++) begin
      m_pkt[m][i]  = 0;
      m_beat[m][i] = 0;
    end
  endtask

  function automatic bit present(input int c);
    return in_data_v[c] && in_flags_v[c] && in_eop_v[c];
  endfunction

  // Check one instance against its model for the current cycle, then advance
  // the model across the coming rising edge.
  task automatic step_model(input int m);
    logic [2:0]      ov;
    logic [DW-1:0]   od;
    logic [7:0]      of;
    logic [DB-1:0]   oe;
    logic [CW-1:0]   oc;
    logic [NCH-1:0]  rd, rf, re, er;
    logic [CNTW-1:0] pc [NCH];
    logic [CNTW-1:0] bc [NCH];
    string           pfx;
    int              g;
    bit              drain, space;

    pfx = (m == 0) ? "rr" : "fp";
    if (m == 0) begin
      ov = {a_out_dv, a_out_fv, a_out_ev}; od = a_out_d; of = a_out_f; oe = a_out_e; oc = a_chan;
      for (int i = 0; i < NCH; i++) begin
        rd[i] = a_data_r[i]; rf[i] = a_flags_r[i]; re[i] = a_eop_r[i];
        pc[i] = a_pkt[i]; bc[i] = a_beat[i];
      end
    end else begin
      ov = {b_out_dv, b_out_fv, b_out_ev}; od = b_out_d; of = b_out_f; oe = b_out_e; oc = b_chan;
      for (int i = 0; i < NCH; i++) begin
        rd[i] = b_data_r[i]; rf[i] = b_flags_r[i]; re[i] = b_eop_r[i];
        pc[i] = b_pkt[i]; bc[i] = b_beat[i];
      end
    end

    if (!rst_n) model_reset(m);

    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("%s_pkt_cnt%0d", pfx, i), 64'(pc[i]), 64'(m_pkt[m][i]));
      check_eq($sformatf("%s_beat_cnt%0d", pfx, i), 64'(bc[i]), 64'(m_beat[m][i]));
    end
    check_eq({pfx, "_out_valids"}, 64'(ov), m_full[m] ? 64'h7 : 64'h0);
    if (!rst_n) begin
      check_eq({pfx, "_rst_data"}, 64'(od), 64'h0);
      check_eq({pfx, "_rst_flags"}, 64'(of), 64'h0);
      check_eq({pfx, "_rst_eop"}, 64'(oe), 64'h0);
      check_eq({pfx, "_rst_chan"}, 64'(oc), 64'h0);
    end else if (m_full[m]) begin
      check_eq({pfx, "_out_data"}, 64'(od), 64'(m_slot[m].d));
      check_eq({pfx, "_out_flags"}, 64'(of), 64'(m_slot[m].f));
      check_eq({pfx, "_out_eop"}, 64'(oe), 64'(m_slot[m].e));
      check_eq({pfx, "_out_chan"}, 64'(oc), 64'(m_slot[m].ch));
    end

    // Which channel should be granted this cycle.
    g = -1;
    if (m_lock[m] >= 0) begin
      if (present(m_lock[m])) g = m_lock[m];
    end else if (m == 0) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_rr[m] + k) % NCH;
        if (g < 0 && ch_en[c] && present(c)) g = c;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (g < 0 && ch_en[c] && present(c)) g = c;
      end
    end

    drain = m_full[m] && out_data_r && out_flags_r && out_eop_r;
    space = !m_full[m] || drain;
    er = '0;
    if (rst_n && space && g >= 0) er[g] = 1'b1;
    check_eq({pfx, "_data_r"}, 64'(rd), 64'(er));
    check_eq({pfx, "_flags_r"}, 64'(rf), 64'(er));
    check_eq({pfx, "_eop_r"}, 64'(re), 64'(er));

    if (!rst_n) return;

    if (drain) m_full[m] = 1'b0;
    if (space && g >= 0) begin
      m_full[m]    = 1'b1;
      m_slot[m].d  = in_data_d[g];
      m_slot[m].f  = in_flags_d[g];
      m_slot[m].e  = in_eop_d[g];
      m_slot[m].ch = g;
      m_beat[m][g]++;
      if (in_eop_d[g] != '0) begin
        m_pkt[m][g]++;
        m_lock[m] = -1;
        m_rr[m]   = (g + 1) % NCH;
      end else begin
        m_lock[m] = g;
      end
    end
    if (clr_cnt) begin
      for (int i = 0; i < NCH; i++) begin
        m_pkt[m][i]  = 0;
        m_beat[m][i] = 0;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int stall = 0;

  task automatic drive_random();
    for (int i = 0; i < NCH; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        in_data_v[i] = 1'b1; in_flags_v[i] = 1'b1; in_eop_v[i] = 1'b1;
      end else begin
        in_data_v[i]  = 1'($urandom_range(0, 1));
        in_flags_v[i] = 1'($urandom_range(0, 1));
        in_eop_v[i]   = 1'($urandom_range(0, 1));
      end
      in_data_d[i]  = {$urandom, $urandom};
      in_flags_d[i] = 8'($urandom);
      in_eop_d[i]   = ($urandom_range(0, 2) == 0) ? DB'($urandom_range(1, 255)) : '0;
    end
    if ($urandom_range(0, 7) == 0) ch_en = NCH'($urandom);
    if ($urandom_range(0, 15) == 0) ch_en = '1;
    if (stall > 0) begin
      stall--;
      out_data_r = 1'b0; out_flags_r = 1'b0; out_eop_r = 1'b0;
    end else if ($urandom_range(0, 29) == 0) begin
      stall = 4;
      out_data_r = 1'b0; out_flags_r = 1'b0; out_eop_r = 1'b0;
    end else begin
      out_data_r  = ($urandom_range(0, 7) != 0);
      out_flags_r = ($urandom_range(0, 7) != 0);
      out_eop_r   = ($urandom_range(0, 7) != 0);
    end
    clr_cnt = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    bit did_mid_rst;
    int rst_hold;
    did_mid_rst = 1'b0;
    rst_hold    = 0;
    ch_en = '1;
    clr_cnt = 1'b0;
    out_data_r = 1'b1; out_flags_r = 1'b1; out_eop_r = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      in_data_d[i] = '0; in_flags_d[i] = '0; in_eop_d[i] = '0;
      in_data_v[i] = 1'b0; in_flags_v[i] = 1'b0; in_eop_v[i] = 1'b0;
    end
    model_reset(0);
    model_reset(1);

    // Reset state, with random traffic offered while reset is held.
    repeat (2) begin
      @(negedge clk);
      drive_random();
      #1;
      step_model(0);
      step_model(1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if (!did_mid_rst && cyc > NCYC / 2 && m_lock[0] >= 0 && m_full[0]) begin
        // Abandon a packet in flight; outputs must clear immediately.
        did_mid_rst = 1'b1;
        rst_n       = 1'b0;
        rst_hold    = 2;
      end
      drive_random();
      #1;
      step_model(0);
      step_model(1);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
